serial_frame_tx: RTL and testbench

//  Parametrised successor to the byte-packing shift-out serialiser: buffers up to DEPTH words, then transmits them on send.

---
 rtl/serial_pkg.sv | 23 ++
 rtl/serial_frame_tx_if.sv | 33 +++
 rtl/serial_bit_timer.sv | 50 +++++
 rtl/serial_frame_tx.sv | 206 ++++++++++++++++++++
 tb/tb_serial_frame_tx.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the serial frame transmitter:
//   - state_t   : transmitter FSM state encoding
//   - TX_IDLE   : line level while nothing is being sent
//   - START_BIT : level of the frame start bit
//   - STOP_BIT  : level of the frame stop bit
// -----------------------------------------------------------------------------
package serial_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic TX_IDLE   = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_frame_tx_if.sv
// -----------------------------------------------------------------------------
// serial_frame_tx_if
// Groups the buffer-write / transmit-control / status signals of the serial
// frame transmitter.
//   data, get, send                     : driven by the producer (master)
//   tx, busy, done, level, overflow     : driven by the transmitter (slave)
// -----------------------------------------------------------------------------
interface serial_frame_tx_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 6
);
    localparam int LW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] data;
    logic              get;
    logic              send;
    logic              tx;
    logic              busy;
    logic              done;
    logic [LW-1:0]     level;
    logic              overflow;

    modport master (
        output data, get, send,
        input  tx, busy, done, level, overflow
    );

    modport slave (
        input  data, get, send,
        output tx, busy, done, level, overflow
    );

endinterface

// File: rtl/serial_bit_timer.sv
// -----------------------------------------------------------------------------
// serial_bit_timer
// Counts clk cycles inside one transmitted bit.
//   clk     : system clock, rising edge
//   rst     : synchronous reset, active-high
//   run     : count while high; the counter is cleared while low
//   bit_end : high on the last cycle of each bit (count == CLKS_PER_BIT-1)
// -----------------------------------------------------------------------------
module serial_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic bit_end
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Last-cycle flag of the current bit.
    always_comb begin
        bit_end = run && (cnt_q == LAST);
    end

    // Next count: clear when stopped, wrap after the last cycle of a bit.
    always_comb begin
        cnt_d = cnt_q;
        if (!run) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == LAST) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Cycle counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// -----------------------------------------------------------------------------
// serial_frame_tx
// Buffers up to DEPTH words, then on send transmits all of them as
// asynchronous frames: start bit, DATA_W data bits LSB first, optional even
// parity bit, stop bit. Each bit lasts CLKS_PER_BIT clk cycles.
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : serial_frame_tx_if.slave
//          data/get    - word to buffer and its write strobe
//          send        - start transmitting everything buffered
//          tx          - serial line, idle high
//          busy        - transmission in progress
//          done        - one-cycle pulse when the last stop bit completes
//          level       - number of buffered words
//          overflow    - one-cycle pulse when a get is rejected
// Build option: define SERIAL_FRAME_TX_PARITY_EN to add an even parity bit.
// -----------------------------------------------------------------------------
module serial_frame_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 6,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    serial_frame_tx_if.slave  bus
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    function automatic logic even_parity(input logic [DATA_W-1:0] w);
        return ^w;
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_t        state_q,    state_d;
    logic [BW-1:0] bit_idx_q,  bit_idx_d;
    logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [LW-1:0] level_q,    level_d;
    logic          tx_q,       tx_d;
    logic          busy_q,     busy_d;
    logic          done_q,     done_d;
    logic          overflow_q, overflow_d;
    logic          wr_en_s;
    logic          run_s;
    logic          bit_end_s;

    assign run_s = (state_q != ST_IDLE);

    serial_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (run_s),
        .bit_end (bit_end_s)
    );

    // Buffer writes, FSM next state, pointer/level updates and the next line level.
    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        wr_en_s    = 1'b0;
        overflow_d = 1'b0;
        done_d     = 1'b0;
        tx_d       = TX_IDLE;

        // Words are only accepted while idle and not full.
        if (bus.get) begin
            if ((state_q == ST_IDLE) && (level_q != LW'(DEPTH))) begin
                wr_en_s  = 1'b1;
                wr_ptr_d = ptr_inc(wr_ptr_q);
                level_d  = level_q + LW'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end else begin
            wr_en_s = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // A word written in the same cycle counts towards a non-empty buffer.
                if (bus.send && ((level_q != LW'(0)) || wr_en_s)) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    if (bit_idx_q == BW'(DATA_W - 1)) begin
                        bit_idx_d = {BW{1'b0}};
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    rd_ptr_d = ptr_inc(rd_ptr_q);
                    level_d  = level_q - LW'(1);
                    if (level_q > LW'(1)) begin
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The line is registered, so it is derived from the state being entered.
        case (state_d)
            ST_IDLE:   tx_d = TX_IDLE;
            ST_START:  tx_d = START_BIT;
            ST_DATA:   tx_d = mem_q[rd_ptr_q][bit_idx_d];
            ST_PARITY: tx_d = even_parity(mem_q[rd_ptr_q]);
            ST_STOP:   tx_d = STOP_BIT;
            default:   tx_d = TX_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_idx_q  <= {BW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            wr_ptr_q   <= {PW{1'b0}};
            level_q    <= {LW{1'b0}};
            tx_q       <= TX_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    // Word buffer; contents need no reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_en_s) begin
            mem_q[wr_ptr_q] <= bus.data;
        end
    end

    assign bus.tx       = tx_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.level    = level_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx (DATA_W=8, DEPTH=6, CLKS_PER_BIT=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_serial_frame_tx;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 6;
    localparam int CPB    = 4;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic [7:0] data = 8'h00;
    logic       get  = 1'b0;
    logic       send = 1'b0;

    int errors = 0;
    int checks = 0;

    // Words expected to go out on the next transmission, oldest first.
    logic [7:0] model_q [$];

    serial_frame_tx_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    assign bus.data = data;
    assign bus.get  = get;
    assign bus.send = send;

    serial_frame_tx #(
        .DATA_W       (DATA_W),
        .DEPTH        (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Writes n words (random, or a fixed word when n==1 and fixed_en) to DUT and model.
    task automatic load_words(input int n, input bit fixed_en, input logic [7:0] fixed_w);
        for (int k = 0; k < n; k++) begin
            data = fixed_en ? fixed_w : 8'($urandom_range(0, 255));
            get  = 1'b1;
            model_q.push_back(data);
            @(negedge clk);
        end
        get = 1'b0;
    endtask

    // Follows a transmission started by the caller (send driven before the call).
    // inject_at: cycle index at which get+send are pulsed while busy (-10 = never).
    // abort_at : cycle index at which reset is pulsed (-10 = never).
    task automatic run_tx(input int inject_at, input int abort_at);
        logic       exp_bits [$];
        logic [7:0] w;
        int         total;
        foreach (model_q[k]) begin
            w = model_q[k];
            exp_bits.push_back(1'b0);
            for (int b = 0; b < DATA_W; b++) exp_bits.push_back(w[b]);
            if (P == 1) exp_bits.push_back(^w);
            exp_bits.push_back(1'b1);
        end
        total = exp_bits.size() * CPB;
        @(negedge clk);
        send = 1'b0;
        get  = 1'b0;
        for (int i = 0; i < total; i++) begin
            checks++; if (bus.tx !== exp_bits[i / CPB]) begin errors++; $display("FAIL tx_bit cycle %0d: got %b want %b", i, bus.tx, exp_bits[i / CPB]); end
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_high cycle %0d: got %b want 1", i, bus.busy); end
            checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done_early cycle %0d: got %b want 0", i, bus.done); end
            if (i == inject_at + 1) begin
                checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL overflow_busy cycle %0d: got %b want 1", i, bus.overflow); end
            end else begin
                checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL overflow_quiet cycle %0d: got %b want 0", i, bus.overflow); end
            end
            get  = 1'b0;
            send = 1'b0;
            if (i == inject_at) begin
                data = 8'h3C;
                get  = 1'b1;
                send = 1'b1;
            end
            if (i == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                checks++; if (bus.tx !== 1'b1) begin errors++; $display("FAIL abort_tx: got %b want 1", bus.tx); end
                checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
                checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL abort_level: got %0d want 0", bus.level); end
                checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", bus.done); end
                model_q.delete();
                return;
            end
            @(negedge clk);
        end
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL done_pulse: got %b want 1", bus.done); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_fall: got %b want 0", bus.busy); end
        checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL level_end: got %0d want 0", bus.level); end
        checks++; if (bus.tx !== 1'b1) begin errors++; $display("FAIL tx_idle_end: got %b want 1", bus.tx); end
        model_q.delete();
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done_single: got %b want 0", bus.done); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", bus.tx); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", bus.level); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        for (int r = 0; r < 4; r++) begin
            load_words(1, (r == 0), 8'hA5);
            checks++; if (bus.level !== 3'd1) begin errors++; $display("FAIL single_level: got %0d want 1", bus.level); end
            send = 1'b1;
            run_tx(-10, -10);
        end
    endtask

    task automatic test_multi_frame();
        logic [2:0] exp_lvl;
        load_words(DEPTH, 1'b0, 8'h00);
        exp_lvl = 3'(model_q.size());
        checks++; if (bus.level !== exp_lvl) begin errors++; $display("FAIL multi_level: got %0d want %0d", bus.level, exp_lvl); end
        send = 1'b1;
        run_tx(-10, -10);
    endtask

    task automatic test_overflow_full();
        logic [2:0] exp_lvl;
        for (int k = 0; k < DEPTH + 1; k++) begin
            data = 8'($urandom_range(0, 255));
            get  = 1'b1;
            if (model_q.size() < DEPTH) model_q.push_back(data);
            @(negedge clk);
            exp_lvl = 3'(model_q.size());
            checks++; if (bus.level !== exp_lvl) begin errors++; $display("FAIL full_level get %0d: got %0d want %0d", k, bus.level, exp_lvl); end
            checks++; if (bus.overflow !== (k == DEPTH)) begin errors++; $display("FAIL full_overflow get %0d: got %b want %b", k, bus.overflow, (k == DEPTH)); end
        end
        get = 1'b0;
        @(negedge clk);
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL full_overflow_clear: got %b want 0", bus.overflow); end
        send = 1'b1;
        run_tx(-10, -10);
    endtask

    task automatic test_busy_reject();
        load_words(2, 1'b0, 8'h00);
        send = 1'b1;
        run_tx(12, -10);
    endtask

    task automatic test_reset_mid();
        load_words(3, 1'b0, 8'h00);
        send = 1'b1;
        // frame 1 is 4*(10+P) cycles, then start bit, then 10 cycles into DATA
        run_tx(-10, (10 + P) * CPB + CPB + 10);
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL post_abort_busy %0d: got %b want 0", c, bus.busy); end
            checks++; if (bus.tx !== 1'b1) begin errors++; $display("FAIL post_abort_tx %0d: got %b want 1", c, bus.tx); end
            checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL post_abort_done %0d: got %b want 0", c, bus.done); end
            @(negedge clk);
        end
    endtask

    task automatic test_get_send_same();
        load_words(2, 1'b0, 8'h00);
        data = 8'($urandom_range(0, 255));
        get  = 1'b1;
        send = 1'b1;
        model_q.push_back(data);
        run_tx(-10, -10);
        data = 8'($urandom_range(0, 255));
        get  = 1'b1;
        send = 1'b1;
        model_q.push_back(data);
        run_tx(-10, -10);
    endtask

    task automatic test_send_empty();
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL empty_busy %0d: got %b want 0", c, bus.busy); end
            checks++; if (bus.tx !== 1'b1) begin errors++; $display("FAIL empty_tx %0d: got %b want 1", c, bus.tx); end
            @(negedge clk);
        end
    endtask

`ifdef SERIAL_FRAME_TX_PARITY_EN
    task automatic test_parity();
        load_words(1, 1'b1, 8'h07);
        send = 1'b1;
        run_tx(-10, -10);
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_multi_frame();
        test_overflow_full();
        test_busy_reject();
        test_reset_mid();
        test_get_send_same();
        test_send_empty();
`ifdef SERIAL_FRAME_TX_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
